// File: rtl/spi_slave_pkg.sv
// rtl/spi_slave_pkg.sv - shared SPI definitions: mode decode, idle byte, slave FSM states
package spi_slave_pkg;

  // Byte returned on MISO when nothing has been queued for transmit.
  localparam logic [7:0] SPI_IDLE_BYTE = 8'hFF;

  typedef enum logic {
    ST_IDLE,
    ST_ACTIVE
  } spis_state_e;

  // CPOL is bit 1 of the SPI mode number.
  function automatic logic spi_cpol(input int mode);
    return ((mode >> 1) & 1) != 0;
  endfunction

  // CPHA is bit 0 of the SPI mode number.
  function automatic logic spi_cpha(input int mode);
    return (mode & 1) != 0;
  endfunction

endpackage

// File: rtl/spi_sync.sv
// rtl/spi_sync.sv - multi-stage synchronizer with parameterized reset value
//
// Ports:
//   clk_i   destination clock
//   rst_ni  asynchronous active-low reset (loads RST_VAL into every stage)
//   d_i     asynchronous input
//   q_o     synchronized output (STAGES clocks of latency)
module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// rtl/spi_slave.sv - oversampled SPI slave: byte RX on MOSI, byte TX on MISO
//
// Optional feature macro: SPIS_UNDERRUN_EN (o_TX_Underrun pulse on empty-register load).
//
// Ports:
//   i_Clk, i_Rst_L             system clock (>= 8x SCLK), async active-low reset
//   i_TX_Byte, i_TX_DV         byte offered to the TX holding register
//   o_TX_Ready                 holding register empty
//   o_RX_DV, o_RX_Byte         one-cycle strobe with last complete received byte
//   o_TX_Underrun              one-cycle pulse when a load found the register empty
//   i_SPI_Clk/CS_n/MOSI        SPI pins from the master (asynchronous)
//   o_SPI_MISO, o_SPI_MISO_En  slave data out and its output enable
module spi_slave
  import spi_slave_pkg::*;
#(
  parameter int SPI_MODE    = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic [7:0] i_TX_Byte,
  input  logic       i_TX_DV,
  output logic       o_TX_Ready,
  output logic       o_RX_DV,
  output logic [7:0] o_RX_Byte,
  output logic       o_TX_Underrun,
  input  logic       i_SPI_Clk,
  input  logic       i_SPI_CS_n,
  input  logic       i_SPI_MOSI,
  output logic       o_SPI_MISO,
  output logic       o_SPI_MISO_En
);

  localparam logic CPOL = spi_cpol(SPI_MODE);
  localparam logic CPHA = spi_cpha(SPI_MODE);

  logic rst_n;
  logic sclk_s, csn_s, mosi_s;

  // Reset asserts asynchronously but releases synchronously to i_Clk.
  spi_sync #(.STAGES(2), .RST_VAL(1'b0)) u_rst_sync (
    .clk_i(i_Clk), .rst_ni(i_Rst_L), .d_i(1'b1), .q_o(rst_n)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sclk_sync (
    .clk_i(i_Clk), .rst_ni(rst_n), .d_i(i_SPI_Clk), .q_o(sclk_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_csn_sync (
    .clk_i(i_Clk), .rst_ni(rst_n), .d_i(i_SPI_CS_n), .q_o(csn_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi_sync (
    .clk_i(i_Clk), .rst_ni(rst_n), .d_i(i_SPI_MOSI), .q_o(mosi_s)
  );

  spis_state_e state_q, state_d;
  logic       sclk_q, csn_q;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] rx_sh_q, rx_sh_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic       rx_dv_q, rx_dv_d;
  logic [7:0] tx_sh_q, tx_sh_d;
  logic [7:0] hold_q, hold_d;
  logic       hold_full_q, hold_full_d;
  logic       load;
  logic [7:0] load_byte;

  logic sclk_rise, sclk_fall, lead_edge, trail_edge, sample_edge, shift_edge;
  logic cs_fall, cs_rise;

  assign sclk_rise   = sclk_s & ~sclk_q;
  assign sclk_fall   = ~sclk_s & sclk_q;
  assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
  assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign shift_edge  = CPHA ? lead_edge : trail_edge;
  assign cs_fall     = csn_q & ~csn_s;
  assign cs_rise     = ~csn_q & csn_s;

  assign load_byte = hold_full_q ? hold_q : SPI_IDLE_BYTE;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_sh_d     = rx_sh_q;
    rx_byte_d   = rx_byte_q;
    rx_dv_d     = 1'b0;
    tx_sh_d     = tx_sh_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    load        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d   = ST_ACTIVE;
          bit_cnt_d = 3'd0;
          rx_sh_d   = 7'd0;
          // With CPHA=0 bit 7 must be on MISO before the first sample edge.
          if (!CPHA) begin
            load    = 1'b1;
            tx_sh_d = load_byte;
          end
        end
      end
      ST_ACTIVE: begin
        if (cs_rise) begin
          state_d   = ST_IDLE;
          bit_cnt_d = 3'd0;
          rx_sh_d   = 7'd0;
          tx_sh_d   = 8'd0;
        end else if (sample_edge) begin
          rx_sh_d   = {rx_sh_q[5:0], mosi_s};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rx_byte_d = {rx_sh_q, mosi_s};
            rx_dv_d   = 1'b1;
          end
        end else if (shift_edge) begin
          if (bit_cnt_q == 3'd0) begin
            load    = 1'b1;
            tx_sh_d = load_byte;
          end else begin
            tx_sh_d = {tx_sh_q[6:0], 1'b0};
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (load) begin
      hold_full_d = 1'b0;
    end
    // A write landing on the same cycle as a load of an empty register is kept.
    if (i_TX_DV && !hold_full_q) begin
      hold_d      = i_TX_Byte;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge i_Clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sclk_q      <= CPOL;
      csn_q       <= 1'b1;
      bit_cnt_q   <= 3'd0;
      rx_sh_q     <= 7'd0;
      rx_byte_q   <= 8'd0;
      rx_dv_q     <= 1'b0;
      tx_sh_q     <= 8'd0;
      hold_q      <= 8'd0;
      hold_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_q      <= sclk_s;
      csn_q       <= csn_s;
      bit_cnt_q   <= bit_cnt_d;
      rx_sh_q     <= rx_sh_d;
      rx_byte_q   <= rx_byte_d;
      rx_dv_q     <= rx_dv_d;
      tx_sh_q     <= tx_sh_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end

`ifdef SPIS_UNDERRUN_EN
  logic underrun_q;

  always_ff @(posedge i_Clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun_q <= 1'b0;
    end else begin
      underrun_q <= load && !hold_full_q;
    end
  end

  assign o_TX_Underrun = underrun_q;
`else
  assign o_TX_Underrun = 1'b0;
`endif

  assign o_TX_Ready    = ~hold_full_q;
  assign o_RX_DV       = rx_dv_q;
  assign o_RX_Byte     = rx_byte_q;
  assign o_SPI_MISO    = tx_sh_q[7];
  assign o_SPI_MISO_En = (state_q == ST_ACTIVE);

endmodule

// File: tb/tb_spi_slave.sv
// tb/tb_spi_slave.sv - self-checking bench for spi_slave in all four SPI modes
module tb_spi_slave;

`ifdef SPIS_UNDERRUN_EN
  localparam int UR_EN = 1;
`else
  localparam int UR_EN = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       sclk, mosi;
  logic [3:0] cs_n;
  logic [7:0] tx_byte;
  logic [3:0] tx_dv;
  logic [3:0] tx_ready, rx_dv, urun, miso, miso_en;
  logic [7:0] rx_byte [4];

  always #5 clk = ~clk;

  genvar g;
  generate
    for (g = 0; g < 4; g++) begin : g_dut
      spi_slave #(.SPI_MODE(g), .SYNC_STAGES(2)) u_dut (
        .i_Clk(clk), .i_Rst_L(rst_n),
        .i_TX_Byte(tx_byte), .i_TX_DV(tx_dv[g]), .o_TX_Ready(tx_ready[g]),
        .o_RX_DV(rx_dv[g]), .o_RX_Byte(rx_byte[g]), .o_TX_Underrun(urun[g]),
        .i_SPI_Clk(sclk), .i_SPI_CS_n(cs_n[g]), .i_SPI_MOSI(mosi),
        .o_SPI_MISO(miso[g]), .o_SPI_MISO_En(miso_en[g])
      );
    end
  endgenerate

  int         n_chk = 0;
  int         n_fail = 0;
  int         sel = 0;
  int         urun_cnt = 0;
  logic [7:0] tx_q [$];
  logic [7:0] rx_q [$];

  typedef struct {
    int          mode;
    int          nbits;
    logic [23:0] mo;
    int          ntx;
    logic [23:0] txb;
    logic [23:0] exp_miso;
    int          exp_nrx;
    logic [23:0] exp_rx;
    int          exp_ur;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Refill the selected slave's holding register whenever it reports empty.
  initial begin
    tx_dv   = 4'd0;
    tx_byte = 8'd0;
    forever begin
      @(negedge clk);
      tx_dv = 4'd0;
      if (rst_n && tx_q.size() > 0 && tx_ready[sel]) begin
        tx_byte    = tx_q.pop_front();
        tx_dv[sel] = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (rx_dv[sel]) rx_q.push_back(rx_byte[sel]);
    if (urun[sel]) urun_cnt++;
  end

  task automatic half();
    repeat (8) @(posedge clk);
    #1;
  endtask

  // Master-side transfer: nbits bits of mo (MSB first) under one CS assertion.
  task automatic xfer(input int mode, input int nbits, input logic [23:0] mo,
                      input int ntx, input logic [23:0] txb,
                      output logic [23:0] mi, output int nrx,
                      output logic [23:0] rxcat, output int nur);
    logic cpol, cpha;
    int   rx_base, ur_base;
    cpol = mode[1];
    cpha = mode[0];
    sel  = mode;
    sclk = cpol;
    mosi = 1'b0;
    for (int k = 0; k < ntx; k++) tx_q.push_back(txb[23-8*k -: 8]);
    repeat (16) @(posedge clk);
    #1;
    rx_base = rx_q.size();
    ur_base = urun_cnt;
    mi = 24'd0;
    cs_n[mode] = 1'b0;
    for (int b = 0; b < nbits; b++) begin
      if (!cpha) begin
        mosi = mo[nbits-1-b];
        half();
        sclk = ~cpol;
        mi = {mi[22:0], miso[mode]};
        half();
        sclk = cpol;
      end else begin
        half();
        sclk = ~cpol;
        mosi = mo[nbits-1-b];
        half();
        sclk = cpol;
        mi = {mi[22:0], miso[mode]};
      end
    end
    half();
    cs_n[mode] = 1'b1;
    repeat (24) @(posedge clk);
    #1;
    nrx = rx_q.size() - rx_base;
    rxcat = 24'd0;
    for (int i = rx_base; i < rx_q.size(); i++) rxcat = {rxcat[15:0], rx_q[i]};
    nur = urun_cnt - ur_base;
  endtask

  // Reference: the slave returns queued bytes in order, 8'hFF once they run out;
  // CPHA=0 performs one extra load after the last byte (at CS fall plus after each byte).
  function automatic void model(input int mode, input int n, input int k,
                                input logic [23:0] txb,
                                output logic [23:0] em, output int eur);
    em = 24'd0;
    for (int j = 0; j < n; j++) em = {em[15:0], (j < k) ? txb[23-8*j -: 8] : 8'hFF};
    eur = n + ((mode % 2 == 0) ? 1 : 0) - k;
  endfunction

  task automatic run_check(input string tag, input vec_t v);
    logic [23:0] mi, rxc;
    int          nrx, nur;
    xfer(v.mode, v.nbits, v.mo, v.ntx, v.txb, mi, nrx, rxc, nur);
    check({tag, " miso"}, mi, v.exp_miso);
    check({tag, " rx_dv_count"}, nrx, v.exp_nrx);
    check({tag, " rx_bytes"}, rxc, v.exp_rx);
    check({tag, " underrun_count"}, nur, v.exp_ur * UR_EN);
    if (v.exp_nrx > 0) check({tag, " rx_byte_hold"}, rx_byte[v.mode], v.exp_rx[7:0]);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        vecs [6];
    vec_t        v;
    logic [23:0] em;
    int          eur, n, k;

    vecs[0] = '{0,  8, 24'h00003C, 1, 24'hA50000, 24'h0000A5, 1, 24'h00003C, 1};
    vecs[1] = '{1,  8, 24'h00003C, 1, 24'hA50000, 24'h0000A5, 1, 24'h00003C, 0};
    vecs[2] = '{2,  8, 24'h00003C, 1, 24'hA50000, 24'h0000A5, 1, 24'h00003C, 1};
    vecs[3] = '{3,  8, 24'h00003C, 1, 24'hA50000, 24'h0000A5, 1, 24'h00003C, 0};
    vecs[4] = '{0, 24, 24'h010203, 3, 24'hC1D2E3, 24'hC1D2E3, 3, 24'h010203, 1};
    vecs[5] = '{1,  8, 24'h000055, 0, 24'h000000, 24'h0000FF, 1, 24'h000055, 1};

    rst_n = 1'b0;
    cs_n  = 4'hF;
    sclk  = 1'b0;
    mosi  = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("reset tx_ready", tx_ready[0], 1'b1);
    check("reset rx_dv", rx_dv[0], 1'b0);
    check("reset rx_byte", rx_byte[0], 8'h00);
    check("reset underrun", urun[0], 1'b0);
    check("reset miso", miso, 4'h0);
    check("reset miso_en", miso_en, 4'h0);

    for (int i = 0; i < 6; i++) run_check($sformatf("vec%0d", i), vecs[i]);

    // CS rises after 5 bits; the refilled holding byte must survive to the next transfer.
    v = '{0, 5, 24'h00001E, 2, 24'hC39600, 24'h000018, 0, 24'h000000, 0};
    run_check("abort_partial", v);
    v = '{0, 8, 24'h00000F, 0, 24'h000000, 24'h000096, 1, 24'h00000F, 1};
    run_check("abort_next", v);

    // Reset in the middle of a byte.
    sel = 0;
    sclk = 1'b0;
    half();
    cs_n[0] = 1'b0;
    mosi = 1'b1;
    half();
    sclk = 1'b1;
    half();
    sclk = 1'b0;
    half();
    check("midbyte miso_en", miso_en[0], 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_async tx_ready", tx_ready[0], 1'b1);
    check("rst_async rx_dv", rx_dv[0], 1'b0);
    check("rst_async rx_byte", rx_byte[0], 8'h00);
    check("rst_async underrun", urun[0], 1'b0);
    check("rst_async miso", miso[0], 1'b0);
    check("rst_async miso_en", miso_en[0], 1'b0);
    cs_n[0] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    v = '{0, 8, 24'h0000C4, 1, 24'h5A0000, 24'h00005A, 1, 24'h0000C4, 1};
    run_check("after_reset", v);

    for (int r = 0; r < 10; r++) begin
      v.mode  = $urandom_range(0, 3);
      n       = $urandom_range(1, 3);
      k       = $urandom_range(0, n);
      v.nbits = 8 * n;
      v.mo    = 24'($urandom) & ((24'd1 << v.nbits) - 24'd1);
      v.ntx   = k;
      v.txb   = 24'($urandom);
      model(v.mode, n, k, v.txb, em, eur);
      v.exp_miso = em;
      v.exp_nrx  = n;
      v.exp_rx   = v.mo;
      v.exp_ur   = eur;
      run_check($sformatf("rand%0d_m%0d", r, v.mode), v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
